// File: rtl/ipv4_rx_if.sv
// Beat-stream bundle for the 16-bit IPv4 receive path: one beat per cycle, no backpressure.
interface ipv4_rx_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 2
) ();
  logic              valid;
  logic              start;
  logic              term;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  len;

  modport master (output valid, start, term, data, len);
  modport slave  (input  valid, start, term, data, len);
endinterface

// File: rtl/ipv4_rx.sv
// IPv4 receive header stage: parses/filters/strips the 20-byte header and trims padding.
// Define IPV4_RX_CSUM_EN to build the header checksum checker; otherwise ip_cs_err_o is 0.
module ipv4_rx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 2,
  parameter logic [31:0] DST_IP = 32'hC0A800C7,
  parameter logic [7:0]  PROTO  = 8'd17
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      cancel_i,
  ipv4_rx_if.slave  rx_if,
  ipv4_rx_if.master tx_if,
  output logic      ip_cs_err_o,
  output logic      cancel_o
);

  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StHead    = 4'b0010,
    StPayload = 4'b0100,
    StDrain   = 4'b1000
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [15:0]       rem_q;
  logic              discard_q;
  logic              sent_q;
  logic              cs_err_q;
  logic              valid_q;
  logic              start_q;
  logic              term_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic              cancel_q;

  logic [15:0] w;
  logic        take_start;
  logic        hdr_bad;
  logic        cs_bad;

  // Header words are big-endian: first byte on the wire is the high byte.
  assign w          = {rx_if.data[7:0], rx_if.data[15:8]};
  assign take_start = !cancel_i && rx_if.valid && rx_if.start;

  always_comb begin
    hdr_bad = 1'b0;
    case (cnt_q)
      4'd1:    hdr_bad = w < 16'd21;
      4'd3:    hdr_bad = (w & 16'h3FFF) != 16'h0000;
      4'd4:    hdr_bad = w[7:0] != PROTO;
      4'd8:    hdr_bad = w != DST_IP[31:16];
      4'd9:    hdr_bad = w != DST_IP[15:0];
      default: hdr_bad = 1'b0;
    endcase
  end

`ifdef IPV4_RX_CSUM_EN
  logic [19:0] acc_q;
  logic [19:0] acc_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        head_beat;

  assign head_beat = !cancel_i && rx_if.valid && !rx_if.start && (state_q == StHead);
  assign acc_sum   = acc_q + {4'h0, w};
  // Two end-around-carry folds always suffice for a sum of ten 16-bit words.
  assign fold1     = {1'b0, acc_sum[15:0]} + {13'h0, acc_sum[19:16]};
  assign fold2     = fold1[15:0] + {15'h0, fold1[16]};
  assign cs_bad    = fold2 != 16'hFFFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (take_start) begin
      acc_q <= {4'h0, w};
    end else if (head_beat) begin
      acc_q <= acc_sum;
    end
  end
`else
  assign cs_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      discard_q <= 1'b0;
      sent_q    <= 1'b0;
      cs_err_q  <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      term_q    <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      term_q   <= 1'b0;
      cancel_q <= 1'b0;
      if (cancel_i) begin
        cancel_q <= (state_q == StPayload) && sent_q;
        state_q  <= StIdle;
      end else if (take_start) begin
        // A start beat always restarts header parsing, aborting any frame in flight.
        cancel_q  <= (state_q == StPayload) && sent_q;
        cnt_q     <= 4'd1;
        discard_q <= rx_if.data[7:0] != 8'h45;
        state_q   <= rx_if.term ? StIdle : StHead;
      end else if (rx_if.valid) begin
        unique case (state_q)
          StIdle: begin
          end
          StHead: begin
            if (rx_if.term) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 4'd1;
              if (hdr_bad) discard_q <= 1'b1;
              if (cnt_q == 4'd1) rem_q <= w - 16'd20;
              if (cnt_q == 4'd9) begin
                if (discard_q || hdr_bad) begin
                  state_q <= StDrain;
                end else begin
                  state_q  <= StPayload;
                  sent_q   <= 1'b0;
                  cs_err_q <= cs_bad;
                end
              end
            end
          end
          StPayload: begin
            valid_q <= 1'b1;
            start_q <= !sent_q;
            data_q  <= rx_if.data;
            err_q   <= cs_err_q;
            sent_q  <= 1'b1;
            rem_q   <= rem_q - 16'd2;
            if (rem_q <= 16'd2) begin
              // IP total length ends here; anything beyond is Ethernet padding.
              term_q  <= 1'b1;
              len_q   <= rem_q[LEN_W-1:0];
              state_q <= rx_if.term ? StIdle : StDrain;
            end else begin
              len_q <= rx_if.len;
              if (rx_if.term) begin
                cancel_q <= 1'b1;
                state_q  <= StIdle;
              end
            end
          end
          StDrain: begin
            if (rx_if.term) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx_if.valid = valid_q;
  assign tx_if.start = start_q;
  assign tx_if.term  = term_q;
  assign tx_if.data  = data_q;
  assign tx_if.len   = len_q;
  assign ip_cs_err_o = err_q;
  assign cancel_o    = cancel_q;

endmodule

// File: tb/tb_ipv4_rx.sv
// Bench for ipv4_rx: spec vector table, hand sequences, and randomized frames vs a byte-level model.
`timescale 1ns/1ps
module tb_ipv4_rx;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        valid;
    logic        start;
    logic        term;
    logic        err;
    logic        cancel;
    int          cyc;
  } obs_t;
  typedef obs_t obs_q_t[$];
  typedef struct {
    string       name;
    int          tl;
    int          eth_len;
    logic [7:0]  b0;
    logic [15:0] flags;
    logic [7:0]  proto;
    logic [31:0] dst;
    logic [7:0]  cs_xor;
    int          cancel_at;
    int          exp_beats;
    int          exp_last_len;
    int          exp_err;
    int          exp_cancels;
  } vec_t;

  localparam logic [31:0] DstIp = 32'hC0A800C7;
  localparam logic [7:0]  Proto = 8'd17;
`ifdef IPV4_RX_CSUM_EN
  localparam int CsumEn = 1;
`else
  localparam int CsumEn = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cancel_i = 1'b0;
  logic ip_cs_err_o;
  logic cancel_o;
  int   cyc = 0;
  int   pay_cyc = 0;
  int   tests = 0;
  int   fails = 0;
  obs_t obs_q[$];
  vec_t vecs[13];

  ipv4_rx_if rx_if ();
  ipv4_rx_if tx_if ();

  ipv4_rx dut (
    .clk        (clk),
    .reset      (reset),
    .cancel_i   (cancel_i),
    .rx_if      (rx_if),
    .tx_if      (tx_if),
    .ip_cs_err_o(ip_cs_err_o),
    .cancel_o   (cancel_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && (tx_if.valid || cancel_o)) begin
      obs_t o;
      o.data = tx_if.data; o.len = tx_if.len; o.valid = tx_if.valid; o.start = tx_if.start;
      o.term = tx_if.term; o.err = ip_cs_err_o; o.cancel = cancel_o; o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] key(input obs_t o);
    logic [15:0] d;
    d = o.data;
    if (!o.valid) return {21'h0, 1'b0, o.cancel};
    if (o.len == 2'd1) d[15:8] = 8'h00;
    return {d, o.len, o.valid, o.start, o.term, o.err, o.cancel};
  endfunction

  function automatic logic [15:0] hdr_sum(input byte_q_t b);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 20; i += 2) s += {16'h0, b[i], b[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic build_frame(input int tl, input int eth_len, input logic [7:0] b0,
                             input logic [15:0] flags, input logic [7:0] proto,
                             input logic [31:0] dst, input logic [7:0] cs_xor,
                             output byte_q_t f);
    logic [15:0] cs;
    logic [15:0] tl16;
    tl16 = 16'(tl);
    f = '{b0, 8'h00, tl16[15:8], tl16[7:0], 8'h00, 8'h00, flags[15:8], flags[7:0],
          8'h40, proto, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
          dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
    cs = ~hdr_sum(f);
    f[10] = cs[15:8] ^ cs_xor;
    f[11] = cs[7:0];
    for (int i = 20; i < eth_len; i++) f.push_back(8'($urandom));
  endtask

  // Expected output records straight from the header fields and byte counts.
  task automatic model(input byte_q_t f, input int cancel_at, output obs_q_t q);
    int tl, pay, avail, n, keep;
    bit ok, full, err;
    obs_t o;
    q = {};
    tl = int'({f[2], f[3]});
    ok = (f[0] == 8'h45) && (({f[6], f[7]} & 16'h3FFF) == 16'h0) && (f[9] == Proto) &&
         ({f[16], f[17], f[18], f[19]} == DstIp) && (tl >= 21);
    err = (CsumEn != 0) && (hdr_sum(f) != 16'hFFFF);
    pay = tl - 20;
    avail = f.size() - 20;
    if (ok && avail > 0) begin
      full = avail >= pay;
      n = full ? (pay + 1) / 2 : (avail + 1) / 2;
      for (int j = 0; j < n; j++) begin
        int left;
        left = (full ? pay : avail) - 2 * j;
        o.valid = 1'b1; o.start = (j == 0); o.len = (left >= 2) ? 2'd2 : 2'd1;
        o.data = {(left >= 2) ? f[21 + 2*j] : 8'h00, f[20 + 2*j]};
        o.term = full && (j == n - 1); o.cancel = !full && (j == n - 1);
        o.err = err; o.cyc = 0;
        q.push_back(o);
      end
    end
    if (cancel_at >= 0) begin
      keep = (cancel_at > 10) ? cancel_at - 10 : 0;
      if (keep < q.size()) begin
        while (q.size() > keep) void'(q.pop_back());
        if (keep > 0) begin
          o.valid = 1'b0; o.start = 1'b0; o.term = 1'b0; o.err = 1'b0; o.cancel = 1'b1;
          o.data = '0; o.len = '0;
          q.push_back(o);
        end
      end
    end
  endtask

  task automatic idle();
    rx_if.valid = 1'b0; rx_if.start = 1'b0; rx_if.term = 1'b0;
    rx_if.data = '0; rx_if.len = '0; cancel_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
    end
  endtask

  // Leaves the last beat driven so the next frame can follow back-to-back.
  task automatic send_frame(input byte_q_t f, input int cancel_at, input int stop_at,
                            input int gap_max);
    int nb;
    nb = (f.size() + 1) / 2;
    if (stop_at >= 0 && stop_at < nb) nb = stop_at;
    for (int i = 0; i < nb; i++) begin
      int gaps;
      bit two;
      gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        rx_if.valid = 1'b0; rx_if.start = 1'($urandom); rx_if.term = 1'($urandom);
        rx_if.data = 16'($urandom); rx_if.len = 2'($urandom); cancel_i = 1'b0;
      end
      @(negedge clk);
      two = (2 * i + 1) < f.size();
      rx_if.valid = 1'b1;
      rx_if.start = (i == 0);
      rx_if.term  = (i == (f.size() + 1) / 2 - 1);
      rx_if.data  = {two ? f[2*i + 1] : 8'($urandom), f[2*i]};
      rx_if.len   = two ? 2'd2 : 2'd1;
      cancel_i    = (i == cancel_at);
      if (i == 10) pay_cyc = cyc;
    end
  endtask

  task automatic compare_stream(input obs_q_t exp, input string tag);
    int n;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp.size()));
    n = (obs_q.size() < exp.size()) ? obs_q.size() : exp.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_rec%0d", tag, i), 64'(key(obs_q[i])), 64'(key(exp[i])));
  endtask

  task automatic run_vec(input vec_t v);
    byte_q_t f;
    obs_q_t  exp;
    int beats, last_len, errs, cancels, starts;
    build_frame(v.tl, v.eth_len, v.b0, v.flags, v.proto, v.dst, v.cs_xor, f);
    model(f, v.cancel_at, exp);
    obs_q = {};
    send_frame(f, v.cancel_at, -1, 0);
    idle_cycles(3);
    beats = 0; last_len = 0; errs = 0; cancels = 0; starts = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].valid) beats++;
      if (obs_q[i].valid && obs_q[i].term) last_len = int'(obs_q[i].len);
      if (obs_q[i].valid && obs_q[i].err) errs++;
      if (obs_q[i].valid && obs_q[i].start) starts++;
      if (obs_q[i].cancel) cancels++;
    end
    check({v.name, "_beats"}, 64'(beats), 64'(v.exp_beats));
    check({v.name, "_last_len"}, 64'(last_len), 64'(v.exp_last_len));
    check({v.name, "_err_beats"}, 64'(errs), 64'(v.exp_err != 0 ? v.exp_beats : 0));
    check({v.name, "_cancels"}, 64'(cancels), 64'(v.exp_cancels));
    check({v.name, "_starts"}, 64'(starts), 64'(v.exp_beats > 0 ? 1 : 0));
    compare_stream(exp, v.name);
  endtask

  initial begin
    byte_q_t f;
    obs_q_t  exp;
    obs_q_t  all_exp;

    vecs[0]  = '{"good",      115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, -1, 48, 1, 0, 0};
    vecs[1]  = '{"pad_trim",   28,  46, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, -1,  4, 2, 0, 0};
    vecs[2]  = '{"bad_ver",   115, 115, 8'h46, 16'h4000, 8'd17, DstIp, 8'h00, -1,  0, 0, 0, 0};
    vecs[3]  = '{"good2",     115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, -1, 48, 1, 0, 0};
    vecs[4]  = '{"bad_proto", 115, 115, 8'h45, 16'h4000, 8'd6,  DstIp, 8'h00, -1,  0, 0, 0, 0};
    vecs[5]  = '{"bad_dst",   115, 115, 8'h45, 16'h4000, 8'd17, 32'hC0A80002, 8'h00, -1,
                 0, 0, 0, 0};
    vecs[6]  = '{"frag_mf",   115, 115, 8'h45, 16'h2000, 8'd17, DstIp, 8'h00, -1,  0, 0, 0, 0};
    vecs[7]  = '{"good3",     115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, -1, 48, 1, 0, 0};
    vecs[8]  = '{"bad_csum",  115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h01, -1, 48, 1,
                 CsumEn, 0};
    vecs[9]  = '{"cancel_p5", 115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, 14,  4, 0, 0, 1};
    vecs[10] = '{"trunc_r40", 100,  62, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, -1, 21, 0, 0, 1};
    vecs[11] = '{"cancel_hd", 115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00,  5,  0, 0, 0, 0};
    vecs[12] = '{"good4",     115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, -1, 48, 1, 0, 0};

    idle();
    @(negedge clk);
    check("reset_outputs", 64'({tx_if.valid, tx_if.start, tx_if.term, tx_if.data, tx_if.len,
                               ip_cs_err_o, cancel_o}), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // Good frame: first payload beat appears one cycle after it is accepted.
    build_frame(115, 115, 8'h45, 16'h4000, 8'd17, DstIp, 8'h00, f);
    check("good_hdr_csum", 64'({f[10], f[11]}), 64'h0000_0000_0000_B861);
    model(f, -1, exp);
    obs_q = {};
    send_frame(f, -1, -1, 0);
    idle_cycles(3);
    if (obs_q.size() > 0) check("latency", 64'(obs_q[0].cyc - pay_cyc), 64'd1);
    else check("latency_output_seen", 64'd0, 64'd1);
    compare_stream(exp, "lat_good");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of payload, then a clean frame.
    obs_q = {};
    send_frame(f, -1, 15, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    check("midreset_outputs", 64'({tx_if.valid, tx_if.start, tx_if.term, tx_if.data,
                                  tx_if.len, ip_cs_err_o, cancel_o}), 64'h0);
    reset = 1'b0;
    idle_cycles(2);
    obs_q = {};
    send_frame(f, -1, -1, 0);
    idle_cycles(3);
    compare_stream(exp, "after_reset");

    // Randomized frames, often back-to-back, checked as one continuous stream.
    obs_q = {};
    all_exp = {};
    for (int k = 0; k < 60; k++) begin
      int tl, eth, cancel_at, mode, gap, nb;
      logic [7:0]  b0, proto, csx;
      logic [15:0] flags;
      logic [31:0] dst;
      tl = $urandom_range(120, 21); b0 = 8'h45; proto = Proto; dst = DstIp; csx = 8'h00;
      flags = $urandom_range(1, 0) != 0 ? 16'h4000 : 16'h0000;
      cancel_at = -1;
      case ($urandom_range(9, 0))
        0: b0 = 8'($urandom);
        1: flags = 16'($urandom);
        2: proto = 8'($urandom);
        3: dst = $urandom;
        4: tl = $urandom_range(20, 0);
        5: csx = 8'($urandom_range(255, 1));
        default: ;
      endcase
      mode = $urandom_range(3, 0);
      eth = (tl > 46) ? tl : 46;
      if (mode == 0) eth = eth + $urandom_range(3, 0);
      else if (mode == 1 && tl >= 21) eth = tl;
      else if (mode == 2 && tl - 3 >= 22) eth = $urandom_range(tl - 3, 22);
      build_frame(tl, eth, b0, flags, proto, dst, csx, f);
      nb = (f.size() + 1) / 2;
      if (mode == 3) cancel_at = $urandom_range(nb - 1, 0);
      model(f, cancel_at, exp);
      foreach (exp[i]) all_exp.push_back(exp[i]);
      gap = ($urandom_range(1, 0) != 0) ? 0 : 2;
      send_frame(f, cancel_at, -1, gap);
      if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(3, 1));
    end
    idle_cycles(4);
    compare_stream(all_exp, "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
